// File: rtl/riscv_muldiv_unit.sv
// riscv_muldiv_unit
//   Iterative RV32M/RV64M multiply/divide unit. One multiplier or quotient
//   bit per clock. Operands are converted to magnitudes up front, and the
//   sign is put back in a single FIX cycle at the end.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           request, sampled only while busy = 0
//   kill            abandon the operation in flight (no done, result held)
//   funct3          000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                   100 DIV, 101 DIVU, 110 REM, 111 REMU
//   op_a, op_b      rs1 / rs2 values
//   busy            operation in progress
//   done            one-cycle pulse; result is valid in that cycle
//   result          registered result; holds until the next done
//
// Configuration
//   MULDIV_EARLY_OUT_EN  when defined, a multiply leaves CALC as soon as
//                        the remaining multiplier bits are all zero.
//
// state | meaning
// IDLE  | waiting for start; latches operands and detects special cases
// CALC  | one shift-add (multiply) or restoring-subtract (divide) step per clock
// FIX   | sign correction and output select; pulses done
`timescale 1ns/1ps
module riscv_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_e;

  state_e              state_q,   state_d;
  logic [CW-1:0]       cnt_q,     cnt_d;
  logic [2:0]          funct3_q,  funct3_d;
  logic [XLEN-1:0]     opnd_q,    opnd_d;     // multiplicand or divisor magnitude
  logic [2*XLEN-1:0]   acc_q,     acc_d;      // product, or quotient in low half
  logic [XLEN-1:0]     rem_q,     rem_d;
  logic                neg_q,     neg_d;      // negate product / quotient
  logic                sign_a_q,  sign_a_d;   // negate remainder
  logic                special_q, special_d;  // acc low half already holds the answer
  logic                busy_q,    busy_d;
  logic                done_q,    done_d;
  logic [XLEN-1:0]     result_q,  result_d;

  logic                is_div, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]     a_mag, b_mag, special_val;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   mul_step, prod;
  logic [XLEN-1:0]     quo, remd;

  assign is_div   = funct3[2];
  assign a_neg    = op_a[XLEN-1] & (funct3 inside {3'b001, 3'b010, 3'b100, 3'b110});
  assign b_neg    = op_b[XLEN-1] & (funct3 inside {3'b001, 3'b100, 3'b110});
  assign a_mag    = a_neg ? -op_a : op_a;
  assign b_mag    = b_neg ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign div_ovf  = !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
  // funct3[1] separates REM* from DIV*
  assign special_val = div_zero ? (funct3[1] ? op_a : '1)
                                : (funct3[1] ? '0   : op_a);

  // Shift-add: add the multiplicand into the high half when the current
  // multiplier bit (acc bit 0) is set, then shift the whole accumulator right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide: the partial remainder carries one extra bit so the
  // borrow of the trial subtract lands in the MSB.
  assign div_shift = {rem_q, acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  assign prod = neg_q    ? -acc_q             : acc_q;
  assign quo  = neg_q    ? -acc_q[XLEN-1:0]   : acc_q[XLEN-1:0];
  assign remd = sign_a_q ? -rem_q             : rem_q;

`ifdef MULDIV_EARLY_OUT_EN
  // Remaining multiplier bits sit in acc[cnt:0]. If they are all zero, the
  // outstanding cnt+1 right shifts are applied in one go.
  logic [CW:0]       shamt;
  logic [XLEN-1:0]   rest_mask;
  logic              mul_rest_zero;
  assign shamt         = {1'b0, cnt_q} + (CW+1)'(1);
  assign rest_mask     = ~({XLEN{1'b1}} << shamt);
  assign mul_rest_zero = ((acc_q[XLEN-1:0] & rest_mask) == '0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    funct3_d  = funct3_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    sign_a_d  = sign_a_q;
    special_d = special_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          funct3_d = funct3;
          neg_d    = a_neg ^ b_neg;
          sign_a_d = a_neg;
          rem_d    = '0;
          cnt_d    = CW'(XLEN-1);
          if (is_div && (div_zero || div_ovf)) begin
            // Answer is known now; FIX only forwards it.
            special_d = 1'b1;
            acc_d     = {{XLEN{1'b0}}, special_val};
            state_d   = FIX;
          end else begin
            special_d = 1'b0;
            acc_d     = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
            opnd_d    = is_div ? b_mag : a_mag;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (funct3_q[2]) begin
            rem_d = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], ~div_diff[XLEN]};
          end else begin
            acc_d = mul_step;
          end
          if (cnt_q == '0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
`ifdef MULDIV_EARLY_OUT_EN
          if (!funct3_q[2] && mul_rest_zero) begin
            acc_d   = acc_q >> shamt;
            state_d = FIX;
          end
`endif
        end
      end
      FIX: begin
        if (kill) begin
          state_d = IDLE;
        end else begin
          if (special_q) begin
            result_d = acc_q[XLEN-1:0];
          end else begin
            unique case (funct3_q)
              3'b000:                 result_d = prod[XLEN-1:0];
              3'b001, 3'b010, 3'b011: result_d = prod[2*XLEN-1:XLEN];
              3'b100, 3'b101:         result_d = quo;
              default:                result_d = remd;
            endcase
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      funct3_q  <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      funct3_q  <= funct3_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      sign_a_q  <= sign_a_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
`timescale 1ns/1ps
module tb_riscv_muldiv_unit;

  localparam int XLEN  = 32;
  localparam int LAT_N = XLEN + 1;   // XLEN CALC edges + one FIX edge
  localparam int LAT_S = 1;          // special cases: straight to the done edge
`ifdef MULDIV_EARLY_OUT_EN
  localparam int LAT_M0 = 2;         // 5 x 0: leaves CALC on its first cycle
  localparam int LAT_M3 = 4;         // 5 x 3: two steps, then bits exhausted
`else
  localparam int LAT_M0 = XLEN + 1;
  localparam int LAT_M3 = XLEN + 1;
`endif

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            kill = 1'b0;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            busy, done;
  logic [XLEN-1:0] result;

  riscv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [XLEN-1:0] res;
    int              issue_cyc;
    int              lat;
    int              id;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   next_id  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: compares every done pulse against the oldest outstanding entry.
  logic done_prev = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        check("done_single_cycle", {63'd0, done_prev}, 64'd0);
        check("busy_low_in_done_cycle", {63'd0, busy}, 64'd0);
        if (sb.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: result 0x%0h with nothing outstanding, expected no done", result);
        end else begin
          e = sb.pop_front();
          check($sformatf("result_op%0d", e.id), {32'd0, result}, {32'd0, e.res});
          check($sformatf("latency_op%0d", e.id), 64'(cyc - e.issue_cyc), 64'(e.lat));
        end
      end
      done_prev = done;
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      n_checks++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", w);
    end
  endtask

  task automatic pulse_start(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for busy = 0 (the done cycle when one is pending, giving back-to-back issue).
  task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] res, input int lat);
    exp_t e;
    wait_idle();
    e.res = res; e.issue_cyc = cyc + 1; e.lat = lat; e.id = next_id;
    next_id++;
    sb.push_back(e);
    pulse_start(f, a, b);
  endtask

  initial begin
    int n;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy",   {63'd0, busy},   64'd0);
    check("reset_done",   {63'd0, done},   64'd0);
    check("reset_result", {32'd0, result}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Busy spans edge N up to the edge that raises done.
    issue(F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_N);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles_mul", 64'(n), 64'(XLEN + 1));

    issue(F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_N);
    issue(F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_N);
    issue(F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT_N);
    issue(F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_N);
    issue(F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_N);
    issue(F_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N);
    issue(F_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         LAT_N);
    issue(F_DIVU,   32'd100,       32'd7,         32'd14,        LAT_N);
    issue(F_REMU,   32'd100,       32'd7,         32'd2,         LAT_N);
    issue(F_DIV,    32'h55,        32'd0,         32'hFFFF_FFFF, LAT_S);
    issue(F_REMU,   32'h1234,      32'd0,         32'h1234,      LAT_S);
    issue(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S);
    issue(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_S);
    issue(F_MUL,    32'd5,         32'd0,         32'd0,         LAT_M0);
    issue(F_MUL,    32'd5,         32'd3,         32'd15,        LAT_M3);

    // A start while busy must be dropped; the original DIVU lands on time.
    issue(F_DIVU, 32'd1000, 32'd7, 32'd142, LAT_N);
    repeat (9) @(negedge clk);
    pulse_start(F_DIVU, 32'd50, 32'd5);

    // Kill mid-multiply: no done, result keeps 142.
    wait_idle();
    @(negedge clk);
    pulse_start(F_MUL, 32'd9, 32'd9);
    repeat (5) @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("kill_result_held", {32'd0, result}, 64'd142);

    // Kill and start together in IDLE: nothing accepted.
    kill = 1'b1;
    pulse_start(F_MUL, 32'd3, 32'd3);
    kill = 1'b0;
    check("kill_start_idle_busy", {63'd0, busy}, 64'd0);
    repeat (40) @(negedge clk);
    check("kill_start_idle_result", {32'd0, result}, 64'd142);

    // Asynchronous reset mid-divide.
    pulse_start(F_DIV, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    check("div_running_before_reset", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy",   {63'd0, busy},   64'd0);
    check("async_reset_done",   {63'd0, done},   64'd0);
    check("async_reset_result", {32'd0, result}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    issue(F_DIVU, 32'd100, 32'd7, 32'd14, LAT_N);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d operations still outstanding, expected 0", sb.size());
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
